// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the pipeline writeback
// stage (MEM/WB outputs) and an auxiliary writer (I/O input / interrupt
// context unit). Pipeline writeback has priority. The aux writer waits
// through a valid/ready handshake. If aux is denied for MAX_WAIT consecutive
// cycles, the arbiter freezes the pipeline for one cycle (pipe_stall) and
// gives the port to aux for that cycle.
//
// The register-file write (rf_we/rf_waddr/rf_wdata) is registered, so a
// granted write reaches the register file exactly one cycle after its grant.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous, active-high reset
//   wb_reg_write  in   pipeline writeback enable
//   wb_result     in   pipeline writeback data [7:0]
//   wb_reg_dist   in   pipeline destination register [1:0]
//   aux_valid     in   aux write request (addr/data held until accepted)
//   aux_addr      in   aux destination register [1:0]
//   aux_data      in   aux write data [7:0]
//   aux_ready     out  combinational grant to aux this cycle
//   pipe_stall    out  pipeline freeze request, decoded from the state register
//   rf_we         out  registered register-file write enable
//   rf_waddr      out  registered write address [1:0]
//   rf_wdata      out  registered write data [7:0]
//   force_cnt     out  saturating count of forced-stall cycles [7:0]
//                      (present only when WB_ARB_PERF_EN is defined)
//
// Parameters:
//   MAX_WAIT  consecutive denied aux cycles before a forced stall (1..15)
//   CNT_W     wait-counter width, 2**CNT_W must exceed MAX_WAIT
//
// Build option:
//   WB_ARB_PERF_EN  adds the force_cnt output and its counter.
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wb_reg_write,
    input  logic [7:0] wb_result,
    input  logic [1:0] wb_reg_dist,
    input  logic       aux_valid,
    input  logic [1:0] aux_addr,
    input  logic [7:0] aux_data,
    output logic       aux_ready,
    output logic       pipe_stall,
    output logic       rf_we,
    output logic [1:0] rf_waddr,
    output logic [7:0] rf_wdata
`ifdef WB_ARB_PERF_EN
    ,
    output logic [7:0] force_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             denied;
    logic             in_force;

    // Saturating 8-bit increment used by the forced-stall counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            return val;
        end
        return val + 8'd1;
    endfunction

    assign in_force     = (state == FORCE);
    assign wait_cnt_inc = wait_cnt + CNT_W'(1);

    // Outside FORCE the pipeline owns the port whenever it writes; inside
    // FORCE the wb_* inputs are ignored because MEM/WB is frozen and will
    // re-present the same write once the stall releases.
    always_comb begin
        aux_ready  = 1'b0;
        pipe_stall = 1'b0;
        if (!rst) begin
            pipe_stall = in_force;
            aux_ready  = in_force | ~wb_reg_write;
        end
    end

    assign denied = aux_valid & wb_reg_write & ~in_force;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= 2'd0;
            rf_wdata <= 8'd0;
        end else begin
            // Commit stage: load whichever writer holds the grant this cycle.
            if (in_force) begin
                if (aux_valid) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= aux_addr;
                    rf_wdata <= aux_data;
                end else begin
                    // Stall still happens even if aux withdrew illegally.
                    rf_we <= 1'b0;
                end
            end else if (wb_reg_write) begin
                rf_we    <= 1'b1;
                rf_waddr <= wb_reg_dist;
                rf_wdata <= wb_result;
            end else if (aux_valid) begin
                rf_we    <= 1'b1;
                rf_waddr <= aux_addr;
                rf_wdata <= aux_data;
            end else begin
                rf_we <= 1'b0;
            end

            // Starvation tracking: wait_cnt counts consecutive denied cycles.
            unique case (state)
                IDLE: begin
                    if (denied) begin
                        wait_cnt <= CNT_W'(1);
                        state    <= (MAX_WAIT == 1) ? FORCE : WAIT;
                    end else begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                WAIT: begin
                    if (denied) begin
                        wait_cnt <= wait_cnt_inc;
                        state    <= (wait_cnt_inc == CNT_W'(MAX_WAIT)) ? FORCE : WAIT;
                    end else begin
                        // Accepted or withdrawn: backlog is gone.
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                FORCE: begin
                    // Exactly one stall cycle; never two in a row.
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            force_cnt <= 8'd0;
        end else if (in_force) begin
            force_cnt <= sat_inc8(force_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_reg_write;
    logic [7:0] wb_result;
    logic [1:0] wb_reg_dist;
    logic       aux_valid;
    logic [1:0] aux_addr;
    logic [7:0] aux_data;
    logic       aux_ready;
    logic       pipe_stall;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
`ifdef WB_ARB_PERF_EN
    logic [7:0] force_cnt;
`endif

    int pass_cnt = 0;
    int total    = 0;

    wb_port_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_reg_write (wb_reg_write),
        .wb_result    (wb_result),
        .wb_reg_dist  (wb_reg_dist),
        .aux_valid    (aux_valid),
        .aux_addr     (aux_addr),
        .aux_data     (aux_data),
        .aux_ready    (aux_ready),
        .pipe_stall   (pipe_stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata)
`ifdef WB_ARB_PERF_EN
        ,
        .force_cnt    (force_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_reg_write = 1'b1; wb_reg_dist = 2'd3; wb_result = 8'h11;
        aux_valid = 1'b1; aux_addr = 2'd0; aux_data = 8'h22;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we cyc%0d got %b exp 0", i, rf_we); else pass_cnt++;
            total++; if (pipe_stall !== 1'b0) $display("FAIL reset_stall cyc%0d got %b exp 0", i, pipe_stall); else pass_cnt++;
            total++; if (aux_ready !== 1'b0) $display("FAIL reset_aux_ready cyc%0d got %b exp 0", i, aux_ready); else pass_cnt++;
        end
        total++; if (rf_waddr !== 2'd0 || rf_wdata !== 8'd0) $display("FAIL reset_addr_data got %0d/%h exp 0/00", rf_waddr, rf_wdata); else pass_cnt++;
        rst = 1'b0;
        #1;
        total++; if (aux_ready !== 1'b0) $display("FAIL post_reset_aux_ready got %b exp 0", aux_ready); else pass_cnt++;
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 2'd3 || rf_wdata !== 8'h11)
            $display("FAIL post_reset_first_commit got %b/%0d/%h exp 1/3/11", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        wb_reg_write = 1'b0; aux_valid = 1'b0;
        step();
        total++; if (rf_we !== 1'b0) $display("FAIL reset_idle_we got %b exp 0", rf_we); else pass_cnt++;
    endtask

    task automatic test_idle_aux();
        wb_reg_write = 1'b0; aux_valid = 1'b1; aux_addr = 2'd2; aux_data = 8'h5A;
        #1;
        total++; if (aux_ready !== 1'b1) $display("FAIL idle_aux_ready got %b exp 1", aux_ready); else pass_cnt++;
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 2'd2 || rf_wdata !== 8'h5A)
            $display("FAIL idle_aux_commit got %b/%0d/%h exp 1/2/5a", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        aux_valid = 1'b0;
        step();
        total++; if (rf_we !== 1'b0 || rf_waddr !== 2'd2 || rf_wdata !== 8'h5A)
            $display("FAIL idle_hold got %b/%0d/%h exp 0/2/5a", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
    endtask

    task automatic test_priority();
        wb_reg_write = 1'b1; wb_reg_dist = 2'd1; wb_result = 8'h33;
        aux_valid = 1'b1; aux_addr = 2'd0; aux_data = 8'h77;
        #1;
        total++; if (aux_ready !== 1'b0) $display("FAIL prio_aux_ready got %b exp 0", aux_ready); else pass_cnt++;
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 2'd1 || rf_wdata !== 8'h33)
            $display("FAIL prio_wb_commit got %b/%0d/%h exp 1/1/33", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        wb_reg_write = 1'b0;
        #1;
        total++; if (aux_ready !== 1'b1) $display("FAIL prio_aux_ready_free got %b exp 1", aux_ready); else pass_cnt++;
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 2'd0 || rf_wdata !== 8'h77)
            $display("FAIL prio_aux_commit got %b/%0d/%h exp 1/0/77", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        aux_valid = 1'b0;
        step();
        total++; if (rf_we !== 1'b0) $display("FAIL prio_idle_we got %b exp 0", rf_we); else pass_cnt++;
    endtask

    task automatic test_starvation();
        wb_reg_write = 1'b1; wb_reg_dist = 2'd3; wb_result = 8'h44;
        aux_valid = 1'b1; aux_addr = 2'd1; aux_data = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (pipe_stall !== 1'b0 || aux_ready !== 1'b0)
                $display("FAIL starve_denied cyc%0d stall/ready got %b/%b exp 0/0", i, pipe_stall, aux_ready); else pass_cnt++;
            step();
            total++; if (rf_we !== 1'b1 || rf_waddr !== 2'd3 || rf_wdata !== 8'h44)
                $display("FAIL starve_wb_commit cyc%0d got %b/%0d/%h exp 1/3/44", i, rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        end
        total++; if (pipe_stall !== 1'b1 || aux_ready !== 1'b1)
            $display("FAIL starve_force stall/ready got %b/%b exp 1/1", pipe_stall, aux_ready); else pass_cnt++;
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 2'd1 || rf_wdata !== 8'hC3)
            $display("FAIL starve_aux_commit got %b/%0d/%h exp 1/1/c3", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        total++; if (pipe_stall !== 1'b0) $display("FAIL starve_single_stall got %b exp 0", pipe_stall); else pass_cnt++;
        aux_valid = 1'b0;
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 2'd3 || rf_wdata !== 8'h44)
            $display("FAIL starve_held_wb got %b/%0d/%h exp 1/3/44", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        total++; if (pipe_stall !== 1'b0) $display("FAIL starve_after_stall got %b exp 0", pipe_stall); else pass_cnt++;
`ifdef WB_ARB_PERF_EN
        total++; if (force_cnt !== 8'd1) $display("FAIL perf_cnt_1 got %0d exp 1", force_cnt); else pass_cnt++;
`endif
        wb_reg_write = 1'b0;
        step();
    endtask

    task automatic test_withdraw();
        wb_reg_write = 1'b1; wb_reg_dist = 2'd0; wb_result = 8'h90;
        aux_valid = 1'b1; aux_addr = 2'd3; aux_data = 8'hA5;
        step();
        step();
        aux_valid = 1'b0;
        step();
        total++; if (pipe_stall !== 1'b0) $display("FAIL withdraw_no_stall got %b exp 0", pipe_stall); else pass_cnt++;
        aux_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (pipe_stall !== 1'b0) $display("FAIL withdraw_rearm cyc%0d got %b exp 0", i, pipe_stall); else pass_cnt++;
            step();
        end
        total++; if (pipe_stall !== 1'b1) $display("FAIL withdraw_force got %b exp 1", pipe_stall); else pass_cnt++;
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 2'd3 || rf_wdata !== 8'hA5)
            $display("FAIL withdraw_aux_commit got %b/%0d/%h exp 1/3/a5", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        aux_valid = 1'b0; wb_reg_write = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_force();
        wb_reg_write = 1'b1; wb_reg_dist = 2'd1; wb_result = 8'h5C;
        aux_valid = 1'b1; aux_addr = 2'd2; aux_data = 8'hE1;
        for (int i = 0; i < 4; i++) step();
        total++; if (pipe_stall !== 1'b1) $display("FAIL rstf_force got %b exp 1", pipe_stall); else pass_cnt++;
`ifdef WB_ARB_PERF_EN
        total++; if (force_cnt !== 8'd2) $display("FAIL perf_cnt_2 got %0d exp 2", force_cnt); else pass_cnt++;
`endif
        rst = 1'b1;
        #1;
        total++; if (pipe_stall !== 1'b0 || aux_ready !== 1'b0)
            $display("FAIL rstf_comb_gate stall/ready got %b/%b exp 0/0", pipe_stall, aux_ready); else pass_cnt++;
        step();
        total++; if (rf_we !== 1'b0) $display("FAIL rstf_no_write got %b exp 0", rf_we); else pass_cnt++;
        total++; if (pipe_stall !== 1'b0) $display("FAIL rstf_stall got %b exp 0", pipe_stall); else pass_cnt++;
`ifdef WB_ARB_PERF_EN
        total++; if (force_cnt !== 8'd0) $display("FAIL perf_cnt_rst got %0d exp 0", force_cnt); else pass_cnt++;
`endif
        rst = 1'b0; wb_reg_write = 1'b0;
        #1;
        total++; if (aux_ready !== 1'b1) $display("FAIL rstf_rearb_ready got %b exp 1", aux_ready); else pass_cnt++;
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 2'd2 || rf_wdata !== 8'hE1)
            $display("FAIL rstf_aux_commit got %b/%0d/%h exp 1/2/e1", rf_we, rf_waddr, rf_wdata); else pass_cnt++;
        aux_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_idle_aux();
        test_priority();
        test_starvation();
        test_withdraw();
        test_reset_mid_force();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
